// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage registers: the Tnew width,
// the saturating Tnew decrement, the bubble value and the payload widths
// of the D, E, M and W stages.
package pipe_pkg;

    // Default width of the Tnew field.
    localparam int TNEW_W_DEF = 2;

    // Widest Tnew the helper function handles; callers zero-extend into it.
    localparam int TNEW_MAX_W = 8;

    // Value a zeroed bubble carries. It decodes as a NOP with RegWrite=0
    // and MemWrite=0. Callers cast it to their own field width.
    localparam logic [255:0] BUBBLE = '0;

    // Payload widths of each stage boundary, including PCForTest.
    localparam int PAY_D_W = 64;
    localparam int PAY_E_W = 128;
    localparam int PAY_M_W = 112;
    localparam int PAY_W_W = 80;

    // Tnew counts down by one per stage and never wraps below zero.
    function automatic logic [TNEW_MAX_W-1:0] tnew_sat_dec(input logic [TNEW_MAX_W-1:0] tnew);
        return (tnew == '0) ? '0 : tnew - 1'b1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between pipeline stage N and stage N+1.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender holds valid, data and tnew stable until that edge;
// ready may change at any time and never depends on the data itself.
// The in_* signals face the upstream stage and the out_* signals face the
// downstream stage.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TNEW_W = TNEW_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [TNEW_W-1:0] in_tnew;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TNEW_W-1:0] out_tnew;

    // The stage register itself.
    modport slave (
        input  in_valid, in_data, in_tnew, out_ready,
        output in_ready, out_valid, out_data, out_tnew
    );

    // The surrounding pipeline (upstream producer plus downstream consumer).
    modport master (
        output in_valid, in_data, in_tnew, out_ready,
        input  in_ready, out_valid, out_data, out_tnew
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid/data/tnew entry of a pipeline stage register.
// clear wins over load and turns the entry into a bubble. With ZERO_BUBBLE
// set the bubble payload is forced to zero; otherwise the old payload stays.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TNEW_W      = TNEW_W_DEF,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [TNEW_W-1:0] q_tnew
);
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [TNEW_W-1:0] tnew_d,  tnew_q;

    // Next entry contents: clear beats load, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tnew_d  = tnew_q;
        if (clear) begin
            valid_d = 1'b0;
            if (ZERO_BUBBLE != 0) begin
                data_d = DATA_W'(BUBBLE);
                tnew_d = TNEW_W'(BUBBLE);
            end
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d_data;
            tnew_d  = d_tnew;
        end
    end

    // Entry register; reset empties and zeroes it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tnew_q  <= tnew_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;
    assign q_tnew  = tnew_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic register between pipeline stages N and N+1.
// Carries an opaque payload plus Tnew under a valid/ready handshake, with
// synchronous flush-to-bubble and optional saturating Tnew decrement.
//
// Build option: define PIPE_SKID_EN to add a second (skid) entry so that
// in_ready comes straight from a flop and has no path from out_ready.
// Without it the stage is a single entry with a combinational in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TNEW_W      = TNEW_W_DEF,
    parameter int TNEW_DEC    = 1,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    pipe_stage_reg_if.slave bus
);
    logic              in_ready;
    logic              acc;
    logic              drn;
    logic [TNEW_W-1:0] in_tnew_eff;

    logic              main_load, main_clear;
    logic [DATA_W-1:0] main_ld_data;
    logic [TNEW_W-1:0] main_ld_tnew;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [TNEW_W-1:0] main_tnew;

    // Tnew is adjusted once, as the instruction enters this stage.
    always_comb begin
        in_tnew_eff = bus.in_tnew;
        if (TNEW_DEC != 0) begin
            in_tnew_eff = TNEW_W'(tnew_sat_dec(TNEW_MAX_W'(bus.in_tnew)));
        end
    end

`ifdef PIPE_SKID_EN
    logic              skid_load, skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [TNEW_W-1:0] skid_tnew;

    // Two-entry control: the skid entry absorbs an input accepted while the
    // main entry is stalled, and refills main (oldest first) on the next drain.
    always_comb begin
        in_ready     = ~skid_valid;
        acc          = bus.in_valid & in_ready;
        drn          = main_valid & bus.out_ready;
        main_load    = (drn & skid_valid) | (acc & (~main_valid | drn));
        main_clear   = flush | (drn & ~skid_valid & ~acc);
        main_ld_data = skid_valid ? skid_data : bus.in_data;
        main_ld_tnew = skid_valid ? skid_tnew : in_tnew_eff;
        skid_load    = acc & main_valid & ~drn;
        skid_clear   = flush | (drn & skid_valid);
    end

    pipe_slot #(
        .DATA_W      (DATA_W),
        .TNEW_W      (TNEW_W),
        .ZERO_BUBBLE (ZERO_BUBBLE)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_data  (bus.in_data),
        .d_tnew  (in_tnew_eff),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_tnew  (skid_tnew)
    );
`else
    // Single-entry control: accept whenever the entry is empty, is leaving
    // this cycle, or is being flushed anyway.
    always_comb begin
        in_ready     = ~main_valid | bus.out_ready | flush;
        acc          = bus.in_valid & in_ready;
        drn          = main_valid & bus.out_ready;
        main_load    = acc;
        main_clear   = flush | (drn & ~acc);
        main_ld_data = bus.in_data;
        main_ld_tnew = in_tnew_eff;
    end
`endif

    pipe_slot #(
        .DATA_W      (DATA_W),
        .TNEW_W      (TNEW_W),
        .ZERO_BUBBLE (ZERO_BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .d_data  (main_ld_data),
        .d_tnew  (main_ld_tnew),
        .q_valid (main_valid),
        .q_data  (main_data),
        .q_tnew  (main_tnew)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_tnew  = main_tnew;
endmodule
